// File: rtl/jtframe_mcu_romsrv.sv
// jtframe_mcu_romsrv
// Serves MCU ROM byte fetches from a 2-entry cache of 16-bit SDRAM words and
// refills misses through the framework req/ack/dst handshake. rom_ok is
// combinational from registered state so a hit adds no latency; the MCU
// wrapper stalls the CPU while rom_ok is low.
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   rom_cs, rom_addr  MCU fetch request (byte address)
//   rom_data, rom_ok  returned byte and its valid flag
//   flush             invalidate the cache (ROM download/reload)
//   sdr_req, sdr_addr SDRAM word request towards the bank arbiter
//   sdr_ack           request accepted by the arbiter
//   sdr_dst, sdr_din  data strobe and read data
module jtframe_mcu_romsrv #(
   parameter int unsigned    AW     = 12,
   parameter int unsigned    SAW    = 22,
   parameter logic [SAW-1:0] OFFSET = '0
)(
   input  logic           clk,
   input  logic           rst,
   input  logic           rom_cs,
   input  logic [AW-1:0]  rom_addr,
   output logic [7:0]     rom_data,
   output logic           rom_ok,
   input  logic           flush,
   output logic           sdr_req,
   output logic [SAW-1:0] sdr_addr,
   input  logic           sdr_ack,
   input  logic           sdr_dst,
   input  logic [15:0]    sdr_din
);

   localparam int unsigned TW = AW - 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;

   logic [1:0]          state_q, state_d;
   logic [1:0]          valid_q, valid_d;
   logic [1:0][TW-1:0]  tag_q,   tag_d;
   logic [1:0][15:0]    data_q,  data_d;
   logic                lru_q,   lru_d;
   logic                victim_q, victim_d;
   logic                stale_q, stale_d;
   logic                req_q,   req_d;
   logic [SAW-1:0]      addr_q,  addr_d;
   logic [TW-1:0]       ftag_q,  ftag_d;
   logic [7:0]          last_q,  last_d;

   logic [TW-1:0] cur_tag;
   logic [1:0]    hit;
   logic          hit_idx;
   logic [15:0]   hit_word;
   logic [7:0]    hit_byte;
   logic          fill;
   logic          fill_tgt;

   // Hit detection and byte select, straight from registered cache state
   assign cur_tag  = rom_addr[AW-1:1];
   assign hit[0]   = valid_q[0] && (tag_q[0] == cur_tag);
   assign hit[1]   = valid_q[1] && (tag_q[1] == cur_tag);
   // Tags are kept unique, so at most one entry hits
   assign hit_idx  = hit[1];
   assign hit_word = data_q[hit_idx];
   assign hit_byte = rom_addr[0] ? hit_word[15:8] : hit_word[7:0];

   assign rom_ok   = rom_cs && (hit != 2'b00);
   assign rom_data = rom_ok ? hit_byte : last_q;
   assign sdr_req  = req_q;
   assign sdr_addr = addr_q;

   // A fill whose word already sits in the other entry reuses that entry
   assign fill_tgt = (valid_q[~victim_q] && (tag_q[~victim_q] == ftag_q)) ?
                     ~victim_q : victim_q;

   // Next-state logic: hit bookkeeping, fetch FSM, fill and flush
   always_comb begin
      state_d  = state_q;
      valid_d  = valid_q;
      tag_d    = tag_q;
      data_d   = data_q;
      lru_d    = lru_q;
      victim_d = victim_q;
      stale_d  = stale_q;
      req_d    = req_q;
      addr_d   = addr_q;
      ftag_d   = ftag_q;
      last_d   = last_q;
      fill     = 1'b0;

      if (rom_ok) begin
         lru_d  = ~hit_idx;
         last_d = hit_byte;
      end

      case (state_q)
         ST_IDLE: begin
            if (rom_cs && (hit == 2'b00) && !flush) begin
               ftag_d   = cur_tag;
               victim_d = lru_q;
               addr_d   = OFFSET + SAW'(cur_tag);
               req_d    = 1'b1;
               state_d  = ST_REQ;
            end
         end
         ST_REQ: begin
            if (sdr_ack) begin
               req_d = 1'b0;
               if (sdr_dst) begin
                  fill    = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (sdr_dst) begin
               fill    = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Data from a fetch overlapped by a flush is dropped
      if (fill && !stale_q && !flush) begin
         data_d[fill_tgt]  = sdr_din;
         tag_d[fill_tgt]   = ftag_q;
         valid_d[fill_tgt] = 1'b1;
         lru_d             = ~fill_tgt;
      end

      if (flush) valid_d = 2'b00;

      if (state_d == ST_IDLE)
         stale_d = 1'b0;
      else if (flush)
         stale_d = 1'b1;
   end

   // State registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         valid_q  <= 2'b00;
         tag_q    <= '0;
         data_q   <= '0;
         lru_q    <= 1'b0;
         victim_q <= 1'b0;
         stale_q  <= 1'b0;
         req_q    <= 1'b0;
         addr_q   <= '0;
         ftag_q   <= '0;
         last_q   <= 8'h00;
      end else begin
         state_q  <= state_d;
         valid_q  <= valid_d;
         tag_q    <= tag_d;
         data_q   <= data_d;
         lru_q    <= lru_d;
         victim_q <= victim_d;
         stale_q  <= stale_d;
         req_q    <= req_d;
         addr_q   <= addr_d;
         ftag_q   <= ftag_d;
         last_q   <= last_d;
      end
   end

endmodule
